csr_unit: RTL and testbench
===========================

CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- XLEN, 32, data width.
- CSR_ADDR_W, 12, CSR address width.
- REG_ADDR_W, 5, destination register index width.
- RD_TIMEOUT, 16, maximum cycles waited for CSR read data.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  unit accepts request.
- op  in  3  operation: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; others illegal.
- arg0  in  XLEN  rs1 value.
- rs1  in  REG_ADDR_W  rs1 index, or uimm for immediate ops.
- imm  in  XLEN  CSR address in [CSR_ADDR_W-1:0].
- i_rd  in  REG_ADDR_W  destination index.
- i_error  out  1  illegal op on an accepted-cycle attempt.
- res  out  XLEN  old CSR value.
- o_rd  out  REG_ADDR_W  destination index.
- valid  out  1  result held.
- o_error  out  1  access fault; qualified by valid.
- clear  in  1  consumer pop.
- csr_re  out  1  read strobe.
- csr_ra  out  CSR_ADDR_W  read address.
- csr_rvalid  in  1  read data valid.
- csr_rd  in  XLEN  read data.
- csr_err  in  1  read fault; sampled with csr_rvalid.
- csr_we  out  1  write strobe.
- csr_wa  out  CSR_ADDR_W  write address.
- csr_wd  out  XLEN  write data.

Function
REQ-003 Operand SHALL be arg0 for op[2]=0, and the zero-extended rs1 index for op[2]=1.
REQ-004 Write data SHALL be computed from old value `old`: RW/RWI gives operand; RS/RSI gives old|operand; RC/RCI gives old&~operand.
REQ-005 Read SHALL be skipped for RW/RWI when i_rd==0; res then SHALL be 0.
REQ-006 Write SHALL be skipped for RS/RC/RSI/RCI when rs1==0.
REQ-007 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-008 IDLE: in_ready=1. in_valid with a legal op SHALL latch op, operand, address and rd, then go to READ, or to WRITE if the read is skipped.
REQ-009 IDLE: in_valid with an illegal op SHALL assert i_error combinationally, latch nothing and stay in IDLE.
REQ-010 READ: csr_re=1 and csr_ra=address every cycle until csr_rvalid.
- On csr_rvalid: latch csr_rd into old.
- If csr_err: go to DONE with fault set.
- Otherwise: go to WRITE, or to DONE if the write is skipped.
REQ-011 READ SHALL go to DONE with fault set once RD_TIMEOUT cycles elapse without csr_rvalid.
REQ-012 WRITE SHALL last exactly one cycle and go to DONE.
- If address[CSR_ADDR_W-1:CSR_ADDR_W-2]==2'b11 (read-only CSR): csr_we=0 and fault set.
- Otherwise: csr_we=1, csr_wa=address, csr_wd per REQ-004.
REQ-013 DONE: valid=1, res=old, o_rd=latched rd, o_error=fault; values SHALL be held stable until clear.
REQ-014 clear in DONE SHALL return to IDLE next cycle; clear SHALL be ignored in all other states.
REQ-015 in_ready SHALL be 0 outside IDLE; in_valid SHALL be ignored there.
REQ-016 On a fault, o_rd SHALL be 0 and no write SHALL occur.
REQ-017 csr_re, csr_we, csr_ra, csr_wa and csr_wd SHALL be 0 whenever not driven by REQ-010 or REQ-012.
REQ-018 Latency with zero-wait read and write: request at cycle T gives valid at T+3.

Reset
REQ-019 rst_n low at a clk edge SHALL force IDLE and zero all latched state, including an operation in progress (no write is issued after reset).
REQ-020 Post-reset outputs SHALL be: in_ready=1, valid=0, o_error=0, res=0, o_rd=0, all strobes 0.

Verification
REQ-021 CSRRS, addr 0x300 holding 0x0000_0008, arg0=0x1, rs1=3, rd=7, zero-wait -> res=0x8, o_rd=7, csr_wd=0x9, valid at T+3.
REQ-022 CSRRWI, uimm=5, rd=0 -> no csr_re, csr_we with csr_wd=5, res=0.
REQ-023 CSRRC with rs1=0 -> read only, csr_we never asserted, valid with old value.
REQ-024 CSRRW to 0xC00 -> o_error=1, csr_we=0, o_rd=0; csr_rvalid withheld for 16 cycles -> timeout fault.
REQ-025 op=100 -> i_error=1, FSM stays in IDLE; rst_n low during READ -> IDLE next cycle, no write.

Source files
------------

// File: rtl/csr_unit.sv
// CSR read-modify-write unit: reads the old CSR value, applies RW/RS/RC
// (register or immediate operand), writes it back and holds the result until popped.
module csr_unit #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12,
  parameter int REG_ADDR_W = 5,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [XLEN-1:0]       arg0,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [XLEN-1:0]       imm,
  input  logic [REG_ADDR_W-1:0] i_rd,
  output logic                  i_error,
  output logic [XLEN-1:0]       res,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  valid,
  output logic                  o_error,
  input  logic                  clear,
  output logic                  csr_re,
  output logic [CSR_ADDR_W-1:0] csr_ra,
  input  logic                  csr_rvalid,
  input  logic [XLEN-1:0]       csr_rd,
  input  logic                  csr_err,
  output logic                  csr_we,
  output logic [CSR_ADDR_W-1:0] csr_wa,
  output logic [XLEN-1:0]       csr_wd
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [2:0]            op_reg;
  logic [XLEN-1:0]       operand_reg;
  logic [XLEN-1:0]       old_reg;
  logic [CSR_ADDR_W-1:0] addr_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic                  wr_skip_reg;
  logic                  fault_reg;
  logic [CNT_W-1:0]      cnt_reg;

  logic                  op_legal;
  logic                  rd_skip_in;
  logic                  wr_skip_in;
  logic                  accept;
  logic                  read_only;
  logic                  rd_timeout;
  logic [XLEN-1:0]       operand_in;
  logic [XLEN-1:0]       wdata;
  logic                  unused_imm_hi;

  assign op_legal   = (op[1:0] != 2'b00);
  assign operand_in = op[2] ? XLEN'(rs1) : arg0;
  // RW never needs the old value when it would be discarded; RS/RC with x0 never modify
  assign rd_skip_in = (op[1:0] == 2'b01) && (i_rd == '0);
  assign wr_skip_in = (op[1:0] != 2'b01) && (rs1 == '0);
  assign accept     = (state_reg == IDLE) && in_valid && op_legal;
  assign read_only  = (addr_reg[CSR_ADDR_W-1 -: 2] == 2'b11);
  assign rd_timeout = (cnt_reg == CNT_W'(RD_TIMEOUT - 1));
  assign unused_imm_hi = ^imm[XLEN-1:CSR_ADDR_W];

  always_comb begin
    wdata = '0;
    case (op_reg[1:0])
      2'b01:   wdata = operand_reg;
      2'b10:   wdata = old_reg | operand_reg;
      default: wdata = old_reg & ~operand_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = rd_skip_in ? WRITE : READ;
      READ: begin
        if (csr_rvalid)      state_next = (csr_err || wr_skip_reg) ? DONE : WRITE;
        else if (rd_timeout) state_next = DONE;
      end
      WRITE:   state_next = DONE;
      DONE:    if (clear) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      op_reg      <= '0;
      operand_reg <= '0;
      old_reg     <= '0;
      addr_reg    <= '0;
      rd_reg      <= '0;
      wr_skip_reg <= 1'b0;
      fault_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg      <= op;
            operand_reg <= operand_in;
            addr_reg    <= imm[CSR_ADDR_W-1:0];
            rd_reg      <= i_rd;
            wr_skip_reg <= wr_skip_in;
            old_reg     <= '0;
            fault_reg   <= 1'b0;
            cnt_reg     <= '0;
          end
        end
        READ: begin
          if (csr_rvalid) begin
            old_reg <= csr_rd;
            if (csr_err) fault_reg <= 1'b1;
          end else if (rd_timeout) begin
            fault_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        WRITE: begin
          if (read_only) fault_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign i_error  = (state_reg == IDLE) && in_valid && !op_legal;

  assign csr_re = (state_reg == READ);
  assign csr_ra = csr_re ? addr_reg : '0;
  assign csr_we = (state_reg == WRITE) && !read_only;
  assign csr_wa = csr_we ? addr_reg : '0;
  assign csr_wd = csr_we ? wdata : '0;

  assign valid   = (state_reg == DONE);
  assign res     = valid ? old_reg : '0;
  assign o_rd    = (valid && !fault_reg) ? rd_reg : '0;
  assign o_error = valid && fault_reg;

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: a transaction-level model predicts each access's outcome
// and one monitor process compares the DUT against it every cycle.
module tb_csr_unit;

  localparam int RD_TIMEOUT = 16;
  localparam int PH_RST = 0, PH_POST = 1, PH_IDLE = 2, PH_BUSY = 3;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        err;
    int          re_n;
    int          we_n;
    logic [11:0] wa;
    logic [31:0] wd;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] arg0;
  logic [4:0]  rs1;
  logic [31:0] imm;
  logic [4:0]  i_rd;
  logic        i_error;
  logic [31:0] res;
  logic [4:0]  o_rd;
  logic        valid;
  logic        o_error;
  logic        clear;
  logic        csr_re;
  logic [11:0] csr_ra;
  logic        csr_rvalid;
  logic [31:0] csr_rd;
  logic        csr_err;
  logic        csr_we;
  logic [11:0] csr_wa;
  logic [31:0] csr_wd;

  csr_unit #(.XLEN(32), .CSR_ADDR_W(12), .REG_ADDR_W(5), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .arg0(arg0), .rs1(rs1), .imm(imm), .i_rd(i_rd), .i_error(i_error), .res(res),
    .o_rd(o_rd), .valid(valid), .o_error(o_error), .clear(clear), .csr_re(csr_re),
    .csr_ra(csr_ra), .csr_rvalid(csr_rvalid), .csr_rd(csr_rd), .csr_err(csr_err),
    .csr_we(csr_we), .csr_wa(csr_wa), .csr_wd(csr_wd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR file responder: answers after rsp_wait cycles of continuous csr_re
  int          rsp_wait = 0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err  = 1'b0;
  logic        rsp_hold = 1'b0;
  int          re_run   = 0;
  always @(posedge clk) re_run <= csr_re ? re_run + 1 : 0;
  assign csr_rvalid = csr_re && !rsp_hold && (re_run == rsp_wait);
  assign csr_rd     = csr_rvalid ? rsp_data : '0;
  assign csr_err    = csr_rvalid && rsp_err;

  int   phase  = PH_RST;
  int   txn_id = 0;
  exp_t ex;
  exp_t lit;
  bit   lit_en = 1'b0;

  // Outcome of one access from the rules: which strobes fire, result and cycle count
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a0, input logic [4:0] r1,
                                 input logic [11:0] ad, input logic [4:0] rdv, input logic [31:0] old_v,
                                 input int wt, input bit er, input bit hd);
    exp_t        e;
    logic [31:0] opnd, old;
    bit          do_rd, fault;
    int          rcyc, wvisit;
    opnd  = o[2] ? {27'd0, r1} : a0;
    do_rd = !(o[1:0] == 2'b01 && rdv == 5'd0);
    fault = 1'b0;
    old   = '0;
    rcyc  = 0;
    if (do_rd) begin
      if (hd || wt >= RD_TIMEOUT) begin
        rcyc  = RD_TIMEOUT;
        fault = 1'b1;
      end else begin
        rcyc  = wt + 1;
        old   = old_v;
        fault = er;
      end
    end
    wvisit = (!fault && !(o[1:0] != 2'b01 && r1 == 5'd0)) ? 1 : 0;
    e.we_n = 0;
    e.wa   = '0;
    e.wd   = '0;
    if (wvisit == 1) begin
      if (ad[11:10] == 2'b11) fault = 1'b1;
      else begin
        e.we_n = 1;
        e.wa   = ad;
        if (o[1:0] == 2'b01)      e.wd = opnd;
        else if (o[1:0] == 2'b10) e.wd = old | opnd;
        else                      e.wd = old & ~opnd;
      end
    end
    e.res  = old;
    e.rd   = fault ? 5'd0 : rdv;
    e.err  = fault;
    e.re_n = rcyc;
    e.lat  = rcyc + wvisit + 1;
    return e;
  endfunction

  // ---------------- compare process (sole owner of the counters) ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  initial begin : monitor
    int          last_id = 0;
    int          t0 = 0;
    int          re_n = 0;
    int          we_n = 0;
    logic [11:0] got_wa = '0;
    logic [31:0] got_wd = '0;
    bit          seen_valid = 1'b0;
    bit          late = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && phase != PH_RST) begin
        if (!csr_re) chk("ra_zero", 32'(csr_ra), 32'd0);
        if (!csr_we) begin
          chk("wa_zero", 32'(csr_wa), 32'd0);
          chk("wd_zero", csr_wd, 32'd0);
        end
        if (phase == PH_POST) begin
          chk("rst_ready", 32'(in_ready), 32'd1);
          chk("rst_valid", 32'(valid), 32'd0);
          chk("rst_oerr", 32'(o_error), 32'd0);
          chk("rst_res", res, 32'd0);
          chk("rst_ord", 32'(o_rd), 32'd0);
          chk("rst_re", 32'(csr_re), 32'd0);
          chk("rst_we", 32'(csr_we), 32'd0);
        end else if (phase == PH_IDLE) begin
          chk("idle_ready", 32'(in_ready), 32'd1);
          chk("idle_valid", 32'(valid), 32'd0);
          chk("idle_re", 32'(csr_re), 32'd0);
          chk("idle_we", 32'(csr_we), 32'd0);
          chk("i_error", 32'(i_error), 32'(in_valid && op[1:0] == 2'b00));
        end else begin
          if (txn_id != last_id) begin
            last_id = txn_id; t0 = cyc; re_n = 0; we_n = 0;
            got_wa = '0; got_wd = '0; seen_valid = 1'b0; late = 1'b0;
            chk("req_ready", 32'(in_ready), 32'd1);
          end else begin
            chk("busy_ready", 32'(in_ready), 32'd0);
          end
          chk("busy_ierr", 32'(i_error), 32'd0);
          if (csr_re) begin
            re_n++;
            chk("csr_ra", 32'(csr_ra), 32'(ex.wa == 12'd0 ? csr_ra : ex.wa));
          end
          if (csr_we) begin
            we_n++;
            got_wa = csr_wa;
            got_wd = csr_wd;
          end
          if (valid) begin
            if (!seen_valid) begin
              seen_valid = 1'b1;
              chk("latency", 32'(cyc - t0), 32'(ex.lat));
              chk("read_cycles", 32'(re_n), 32'(ex.re_n));
              chk("writes", 32'(we_n), 32'(ex.we_n));
              chk("csr_wa", 32'(got_wa), 32'(ex.wa));
              chk("csr_wd", got_wd, ex.wd);
              chk("res", res, ex.res);
              chk("o_rd", 32'(o_rd), 32'(ex.rd));
              chk("o_error", 32'(o_error), 32'(ex.err));
              if (lit_en) begin
                chk("lit_latency", 32'(cyc - t0), 32'(lit.lat));
                chk("lit_reads", 32'(re_n), 32'(lit.re_n));
                chk("lit_writes", 32'(we_n), 32'(lit.we_n));
                chk("lit_wa", 32'(got_wa), 32'(lit.wa));
                chk("lit_wd", got_wd, lit.wd);
                chk("lit_res", res, lit.res);
                chk("lit_ord", 32'(o_rd), 32'(lit.rd));
                chk("lit_oerr", 32'(o_error), 32'(lit.err));
              end
            end else begin
              chk("hold_res", res, ex.res);
              chk("hold_ord", 32'(o_rd), 32'(ex.rd));
              chk("hold_oerr", 32'(o_error), 32'(ex.err));
              chk("done_re", 32'(csr_re), 32'd0);
              chk("done_we", 32'(csr_we), 32'd0);
            end
          end else if (!late && (cyc - t0) > ex.lat) begin
            late = 1'b1;
            chk("valid_deadline", 32'(valid), 32'd1);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input logic [2:0] o, input logic [31:0] a0, input logic [4:0] r1,
                     input logic [11:0] ad, input logic [4:0] rdv, input logic [31:0] old_v,
                     input int wt, input bit er, input bit hd, input bit spam);
    @(posedge clk); #1;
    rsp_wait = wt; rsp_data = old_v; rsp_err = er; rsp_hold = hd;
    ex = model(o, a0, r1, ad, rdv, old_v, wt, er, hd);
    // read-address expectation travels in the same record; write address may be 0
    if (ex.we_n == 0) ex.wa = '0;
    in_valid = 1'b1; op = o; arg0 = a0; rs1 = r1; imm = {20'hABCDE, ad}; i_rd = rdv;
    phase = PH_BUSY; txn_id++;
    exp_addr_for_reads(ad);
    @(posedge clk); #1;
    if (spam) begin
      in_valid = 1'b1; op = 3'b001; arg0 = 32'h1357_9BDF; rs1 = 5'd9; imm = 32'h3FF; i_rd = 5'd12;
    end else in_valid = 1'b0;
    for (int k = 0; k < 60 && !valid; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0; phase = PH_IDLE; lit_en = 1'b0;
  endtask

  logic [11:0] read_addr = '0;
  task automatic exp_addr_for_reads(input logic [11:0] ad);
    read_addr = ad;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; arg0 = '0; rs1 = '0; imm = '0; i_rd = '0; clear = 1'b0;
    phase = PH_RST;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; phase = PH_POST;
    @(posedge clk); #1 phase = PH_IDLE;

    // illegal opcodes are flagged and nothing starts
    @(posedge clk); #1 in_valid = 1'b1; op = 3'b100; imm = 32'h300; i_rd = 5'd4;
    @(posedge clk); #1 op = 3'b000;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);

    // CSRRS 0x300 = 0x8 | 0x1
    lit = '{res: 32'h8, rd: 5'd7, err: 1'b0, re_n: 1, we_n: 1, wa: 12'h300, wd: 32'h9, lat: 3};
    lit_en = 1'b1;
    run(3'b010, 32'h1, 5'd3, 12'h300, 5'd7, 32'h8, 0, 1'b0, 1'b0, 1'b0);
    // CSRRWI uimm=5 rd=0: no read
    lit = '{res: 32'h0, rd: 5'd0, err: 1'b0, re_n: 0, we_n: 1, wa: 12'h340, wd: 32'h5, lat: 2};
    lit_en = 1'b1;
    run(3'b101, 32'hFFFF_FFFF, 5'd5, 12'h340, 5'd0, 32'h77, 0, 1'b0, 1'b0, 1'b0);
    // CSRRC rs1=0: read only
    lit = '{res: 32'h1234, rd: 5'd9, err: 1'b0, re_n: 1, we_n: 0, wa: 12'h0, wd: 32'h0, lat: 2};
    lit_en = 1'b1;
    run(3'b011, 32'hFF, 5'd0, 12'h305, 5'd9, 32'h1234, 0, 1'b0, 1'b0, 1'b0);
    // CSRRW to read-only 0xC00
    lit = '{res: 32'hABCD, rd: 5'd0, err: 1'b1, re_n: 1, we_n: 0, wa: 12'h0, wd: 32'h0, lat: 3};
    lit_en = 1'b1;
    run(3'b001, 32'h55, 5'd1, 12'hC00, 5'd4, 32'hABCD, 0, 1'b0, 1'b0, 1'b0);
    // read data withheld: timeout fault
    lit = '{res: 32'h0, rd: 5'd0, err: 1'b1, re_n: 16, we_n: 0, wa: 12'h0, wd: 32'h0, lat: 17};
    lit_en = 1'b1;
    run(3'b010, 32'h4, 5'd2, 12'h341, 5'd3, 32'h5, 0, 1'b0, 1'b1, 1'b0);

    run(3'b110, 32'h0, 5'h1F, 12'h341, 5'd2, 32'hF0, 3, 1'b0, 1'b0, 1'b0);          // RSI, 3 wait states
    run(3'b111, 32'h0, 5'h0F, 12'h342, 5'd31, 32'hFFFF, 0, 1'b0, 1'b0, 1'b0);       // RCI
    run(3'b001, 32'h1, 5'd1, 12'h343, 5'd1, 32'h77, 0, 1'b1, 1'b0, 1'b0);           // read fault
    run(3'b001, 32'hDEAD_BEEF, 5'd4, 12'h344, 5'd5, 32'h11, 1, 1'b0, 1'b0, 1'b1);   // RW, in_valid held busy
    run(3'b010, 32'hFF, 5'd0, 12'hC01, 5'd8, 32'h42, 0, 1'b0, 1'b0, 1'b0);          // RS x0 on RO CSR: no fault
    run(3'b101, 32'h0, 5'd3, 12'hC02, 5'd0, 32'h0, 0, 1'b0, 1'b0, 1'b0);            // RWI to RO CSR: fault
    run(3'b010, 32'h2, 5'd1, 12'h345, 5'd10, 32'h1, 15, 1'b0, 1'b0, 1'b0);          // answer on last cycle

    // reset during READ: back to idle, no write afterwards
    @(posedge clk); #1;
    rsp_wait = 0; rsp_data = 32'h3; rsp_err = 1'b0; rsp_hold = 1'b1;
    ex = model(3'b010, 32'h1, 5'd1, 12'h350, 5'd6, 32'h3, 0, 1'b0, 1'b1);
    in_valid = 1'b1; op = 3'b010; arg0 = 32'h1; rs1 = 5'd1; imm = 32'h350; i_rd = 5'd6;
    phase = PH_BUSY; txn_id++;
    read_addr = 12'h350;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; phase = PH_RST;
    @(posedge clk); #1 rst_n = 1'b1; phase = PH_POST; rsp_hold = 1'b0;
    @(posedge clk); #1 phase = PH_IDLE;
    repeat (20) @(posedge clk);

    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
